fpsub_pipeline: RTL and testbench
=================================

Name: fpsub_pipeline

Overview:
Three-stage pipelined FP32 subtractor computing out = A - B. It is the inverse-operation companion to the team's pipelined FP32 adder. It reuses the same operand assumptions: normal inputs with 0<exp<255, and no overflow or underflow checking. It adds a valid/enable handshake and a full cancellation path, with leading-zero normalisation, that the adder does not need.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa field width
BIAS, 127, exponent bias (informational; the datapath never rebiases)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high; clears all pipeline registers on the next clk edge
en  in  1  pipeline advance; 0 = all stages hold
valid_in  in  1  reg_A/reg_B carry a valid operand pair
reg_A  in  32  minuend, FP32
reg_B  in  32  subtrahend, FP32
valid_out  out  1  out holds a result
out  out  32  A - B, FP32, registered

Behaviour:
- Reset and interface:
  - One clock, clk. Reset is synchronous and active-high, port reset.
  - Reset values: valid_out=0, out=32'h0, all internal stage registers 0.
- Latency: exactly 3 enabled clk edges from valid_in sampled high to valid_out high. Throughput is 1 pair per enabled cycle.
- en=0: every stage register, including valid bits, holds. Inputs are ignored. valid_out and out stay stable.
- Each valid bit advances with en, independent of data. A bubble (valid_in=0) propagates as valid_out=0. Data registers still load but are don't-care.
- Stage 1 (unpack/compare), registered:
  - Flip sign_B (effective op = A + (-B)).
  - Prepend the hidden 1 to both mantissas.
  - Order operands by magnitude: larger = greater exp; on a tie, greater mantissa; on a full tie, A.
  - Register: exp_large, diff = exp_large - exp_small (8b), man_large, man_small, result sign = sign of the larger operand, eff_sub = sign_A XOR sign_B_flipped.
- Stage 2 (align/add), registered:
  - Shift man_small right by diff, truncating. diff >= 24 yields 0.
  - Compute a 25-bit sum: man_large + man_small if eff_sub=0, else man_large - man_small (never negative by ordering).
  - Register: sum[24:0], exp_large, sign.
- Stage 3 (normalise/pack), registered into out:
  - sum[24]=1: shift right 1 (truncate), exp+1.
  - sum==0: out = 32'h00000000 (+0, sign forced 0).
  - Otherwise: shift left by lzc(sum[23:0]), exp - lzc.
  - Pack {sign, exp, sum[22:0]}.
- Rounding: truncation only, matching the adder.
- Equal-magnitude, same-sign inputs always give +0.
- Reset asserted mid-stream: in-flight results are discarded, and valid_out=0 from the edge that samples reset. Reset has priority over en.
- Simultaneous reset and valid_in: the pair is dropped.

Decomposition:
- Shared package fp32_pkg holds:
  - field-width constants SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MAN_MSB=22;
  - BIAS;
  - a packed struct fp32_t {sign, exp, man};
  - a function for the hidden-bit mantissa.
- The adder may adopt the same package.
- One sub-module is natural: lzc24, a combinational leading-zero counter with 24b in and 5b count out (24 when the input is 0). It is instantiated in stage 3.

Test Plan:
- 3.0 (40400000) - 1.0 (3F800000), en=1, valid_in pulse at cycle 0 -> valid_out=1 at cycle 3 with out=40000000; valid_out=0 at cycle 4.
- 1.5 (3FC00000) - 1.25 (3FA00000) -> 3E800000 (lzc=2 path). 1.0 - 1.0 -> 00000000.
- 1.0 - 3.0 -> C0000000. 1.0 - (-1.0, BF800000) -> 40000000 (carry path). 1.0 - 2^-30 (30800000) -> 3F800000 (diff>=24).
- Back-to-back stream of 4 pairs, with en=0 held 2 cycles mid-stream -> results emerge in order, each delayed 2 cycles, with out stable while en=0.
- reset=1 for 1 cycle while 3 results are in flight -> valid_out=0 for the next 3 cycles and out=0. A pair issued the cycle after reset deasserts appears 3 cycles later.
- Random normal operands (exp range kept so no over/underflow) against a truncating reference model -> bit-exact match on every valid_out.

Source files
------------

// File: rtl/fp32_pkg.sv
// FP32 field layout, stage bundles and helpers shared by the
// pipelined FP32 adder and subtractor.
package fp32_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int BIAS     = 127;
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef struct packed {
        logic             sign;
        logic             eff_sub;
        logic [EXP_W-1:0] exp;
        logic [EXP_W-1:0] diff;
        logic [MAN_W:0]   man_l;
        logic [MAN_W:0]   man_s;
    } s1_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W+1:0] sum;
    } s2_t;

    function automatic logic [MAN_W:0] hidden_man(fp32_t f);
        return {1'b1, f.man};
    endfunction

endpackage

// File: rtl/fpsub_pipeline_lzc24.sv
// Leading-zero counter over 24 bits; an all-zero input
// reports 24.
module lzc24 (
    input  logic [23:0] d,
    output logic [4:0]  cnt
);

    always_comb begin
        cnt = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (d[i]) cnt = 5'(23 - i);
        end
    end

endmodule

// File: rtl/fpsub_pipeline.sv
// Three-stage FP32 subtractor, out = A - B, truncating, with a
// valid/enable handshake and full cancellation support.
module fpsub_pipeline
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        valid_in,
    input  logic [31:0] reg_A,
    input  logic [31:0] reg_B,
    output logic        valid_out,
    output logic [31:0] out
);

    fp32_t a, b;
    logic  sign_bf;
    logic  a_large;
    logic [MAN_W:0] ma, mb;
    s1_t   s1_d, s1_q;
    s2_t   s2_d, s2_q;
    logic  v1_q, v2_q, v3_q;
    logic [31:0] out_q;

    assign a       = fp32_t'(reg_A);
    assign b       = fp32_t'(reg_B);
    assign sign_bf = ~reg_B[SIGN_BIT];
    assign ma      = hidden_man(a);
    assign mb      = hidden_man(b);

    // Full magnitude tie keeps A as the larger operand.
    assign a_large = (a.exp > b.exp) ||
                     ((a.exp == b.exp) && (ma >= mb));

    always_comb begin
        s1_d         = '0;
        s1_d.eff_sub = reg_A[SIGN_BIT] ^ sign_bf;
        if (a_large) begin
            s1_d.sign  = reg_A[SIGN_BIT];
            s1_d.exp   = a.exp;
            s1_d.diff  = a.exp - b.exp;
            s1_d.man_l = ma;
            s1_d.man_s = mb;
        end else begin
            s1_d.sign  = sign_bf;
            s1_d.exp   = b.exp;
            s1_d.diff  = b.exp - a.exp;
            s1_d.man_l = mb;
            s1_d.man_s = ma;
        end
    end

    logic [MAN_W:0] man_sh;

    always_comb begin
        man_sh = '0;
        if (s1_q.diff < 8'd24) man_sh = s1_q.man_s >> s1_q.diff;
        s2_d      = '0;
        s2_d.sign = s1_q.sign;
        s2_d.exp  = s1_q.exp;
        if (s1_q.eff_sub)
            s2_d.sum = {1'b0, s1_q.man_l} - {1'b0, man_sh};
        else
            s2_d.sum = {1'b0, s1_q.man_l} + {1'b0, man_sh};
    end

    logic [4:0]  lz;
    logic [23:0] norm;
    logic [31:0] res;

    lzc24 u_lzc (
        .d   (s2_q.sum[23:0]),
        .cnt (lz)
    );

    assign norm = s2_q.sum[23:0] << lz;

    always_comb begin
        unique case (1'b1)
            s2_q.sum[24]:
                res = {s2_q.sign, s2_q.exp + 8'd1, s2_q.sum[23:1]};
            (s2_q.sum == '0):
                res = 32'h0;
            default:
                res = {s2_q.sign, s2_q.exp - {3'b0, lz}, norm[22:0]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q  <= '0;
            s2_q  <= '0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            out_q <= '0;
        end else if (en) begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            v1_q  <= valid_in;
            v2_q  <= v1_q;
            v3_q  <= v2_q;
            out_q <= res;
        end
    end

    assign valid_out = v3_q;
    assign out       = out_q;

endmodule

// File: tb/tb_fpsub_pipeline.sv
// Randomised and directed bench for fpsub_pipeline against a
// behavioural truncating FP32 subtract model.
module tb_fpsub_pipeline;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] reg_A = '0;
    logic [31:0] reg_B = '0;
    logic        valid_out;
    logic [31:0] out;

    int n_cmp = 0;
    int n_err = 0;

    fpsub_pipeline dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .valid_in  (valid_in),
        .reg_A     (reg_A),
        .reg_B     (reg_B),
        .valid_out (valid_out),
        .out       (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        int          left;
    } pend_t;

    pend_t       pend[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_out = '0;
    logic        prev_valid;
    logic [31:0] prev_out;

    function automatic logic [31:0] ref_sub(logic [31:0] a, logic [31:0] b);
        int ea = int'(a[30:23]);
        int eb = int'(b[30:23]);
        int ma = int'(a[22:0]) + (1 << 23);
        int mb = int'(b[22:0]) + (1 << 23);
        logic sa = a[31];
        logic sb = ~b[31];
        int el, es, ml, ms, d, sh, s, e;
        logic sg;
        if (ea > eb || (ea == eb && ma >= mb)) begin
            el = ea; es = eb; ml = ma; ms = mb; sg = sa;
        end else begin
            el = eb; es = ea; ml = mb; ms = ma; sg = sb;
        end
        d  = el - es;
        sh = (d >= 24) ? 0 : ms / (1 << d);
        s  = (sa != sb) ? ml - sh : ml + sh;
        if (s == 0) return 32'h0;
        e = el;
        while (s >= (1 << 24)) begin s = s / 2; e++; end
        while (s < (1 << 23)) begin s = s * 2; e--; end
        return {sg, 8'(e), 23'(s)};
    endfunction

    task automatic drive(input logic e, input logic r, input logic v,
                         input logic [31:0] a, input logic [31:0] b);
        en = e; reset = r; valid_in = v; reg_A = a; reg_B = b;
        prev_valid = valid_out;
        prev_out   = out;
        @(posedge clk); #1;
        if (r) begin
            pend.delete();
            m_valid = 1'b0;
            m_out   = '0;
        end else if (e) begin
            m_valid = 1'b0;
            for (int i = 0; i < pend.size(); i++) pend[i].left--;
            if (pend.size() > 0 && pend[0].left == 0) begin
                m_valid = 1'b1;
                m_out   = pend[0].r;
                void'(pend.pop_front());
            end
            if (v) pend.push_back('{ref_sub(a, b), 2});
        end
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] f;
        f[31]    = 1'($urandom);
        f[30:23] = 8'($urandom_range(64, 190));
        f[22:0]  = 23'($urandom);
        return f;
    endfunction

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b0, '0, '0);
        drive(1'b0, 1'b1, 1'b1, 32'h3F800000, 32'h3F800000);
        n_cmp++;
        if (valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b want 0", valid_out);
        end
        n_cmp++;
        if (out !== 32'h0) begin
            n_err++;
            $display("FAIL reset_out: got %h want 00000000", out);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [6] = '{32'h40400000, 32'h3FC00000, 32'h3F800000,
                                32'h3F800000, 32'h3F800000, 32'h3F800000};
        logic [31:0] tb [6] = '{32'h3F800000, 32'h3FA00000, 32'h3F800000,
                                32'h40400000, 32'hBF800000, 32'h30800000};
        logic [31:0] te [6] = '{32'h40000000, 32'h3E800000, 32'h00000000,
                                32'hC0000000, 32'h40000000, 32'h3F800000};
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b0, 1'b1, ta[k], tb[k]);
            drive(1'b1, 1'b0, 1'b0, '0, '0);
            drive(1'b1, 1'b0, 1'b0, '0, '0);
            n_cmp++;
            if (valid_out !== 1'b1 || out !== te[k]) begin
                n_err++;
                $display("FAIL directed_%0d: got v=%b %h want v=1 %h",
                         k, valid_out, out, te[k]);
            end
            drive(1'b1, 1'b0, 1'b0, '0, '0);
            n_cmp++;
            if (valid_out !== 1'b0) begin
                n_err++;
                $display("FAIL directed_%0d_drop: got v=%b want 0", k, valid_out);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic pat_en [12] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
        logic pat_v  [12] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        int seen = 0;
        for (int k = 0; k < 12; k++) begin
            drive(pat_en[k], 1'b0, pat_v[k], rand_fp(), rand_fp());
            n_cmp++;
            if (valid_out !== m_valid) begin
                n_err++;
                $display("FAIL b2b_valid_%0d: got %b want %b", k, valid_out, m_valid);
            end
            if (m_valid) begin
                seen++;
                n_cmp++;
                if (out !== m_out) begin
                    n_err++;
                    $display("FAIL b2b_out_%0d: got %h want %h", k, out, m_out);
                end
            end
            if (!pat_en[k]) begin
                n_cmp++;
                if (out !== prev_out || valid_out !== prev_valid) begin
                    n_err++;
                    $display("FAIL b2b_hold_%0d: got %b/%h want %b/%h",
                             k, valid_out, out, prev_valid, prev_out);
                end
            end
        end
        n_cmp++;
        if (seen != 4) begin
            n_err++;
            $display("FAIL b2b_count: got %0d want 4", seen);
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] a, b;
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b1, rand_fp(), rand_fp());
        drive(1'b1, 1'b1, 1'b1, rand_fp(), rand_fp());
        a = 32'h40400000;
        b = 32'h3F800000;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (valid_out !== 1'b0 || out !== 32'h0) begin
                n_err++;
                $display("FAIL rst_mid_%0d: got v=%b %h want v=0 00000000",
                         k, valid_out, out);
            end
            drive(1'b1, 1'b0, (k == 0), a, b);
        end
        n_cmp++;
        if (valid_out !== 1'b1 || out !== 32'h40000000) begin
            n_err++;
            $display("FAIL rst_mid_after: got v=%b %h want v=1 40000000",
                     valid_out, out);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic e, r, v;
        for (int k = 0; k < 600; k++) begin
            a = rand_fp();
            b = rand_fp();
            case ($urandom_range(0, 7))
                0, 1: b[30:23] = a[30:23];
                2:    b[30:23] = a[30:23] - 8'($urandom_range(0, 2));
                3:    b = {1'($urandom), a[30:0]};
                4:    b = {a[31], a[30:4], 4'($urandom)};
                default: ;
            endcase
            e = ($urandom_range(0, 7) != 0);
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 99) == 0);
            drive(e, r, v, a, b);
            n_cmp++;
            if (valid_out !== m_valid) begin
                n_err++;
                $display("FAIL rand_valid_%0d: got %b want %b", k, valid_out, m_valid);
            end
            if (m_valid) begin
                n_cmp++;
                if (out !== m_out) begin
                    n_err++;
                    $display("FAIL rand_out_%0d: got %h want %h", k, out, m_out);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
